dct_quant_zigzag: RTL and testbench

Downstream stage of the 8-point AAN DCT datapath. Accepts one 8-coefficient vector per beat, eight beats per 8×8 block. Quantizes each coefficient by multiplying with a reciprocal table that already folds in the AAN output scale factors. Emits the 64 quantized values one per cycle in JPEG zigzag order toward the entropy coder, using ping-pong banks so one block fills while the previous drains.

---
 rtl/dct_pkg.sv | 34 +++
 rtl/dct_quant_lane.sv | 49 ++++
 rtl/dct_quant_zigzag.sv | 102 ++++++++++
 tb/tb_dct_quant_zigzag.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants and types for the DCT back end: zigzag scan order and the
// default quantizer reciprocal table (AAN output scale already folded in).
package dct_pkg;

    localparam int NLANE = 8;
    localparam int NCOEF = 64;

    typedef logic signed [15:0] coef_t;

    // Natural (row-major) index of each zigzag position.
    localparam logic [0:63][5:0] ZIGZAG = '{
         6'd0,  6'd1,  6'd8, 6'd16,  6'd9,  6'd2,  6'd3, 6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11,  6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13,  6'd6,  6'd7, 6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Q0.16 reciprocals in natural order.
    localparam logic [0:63][15:0] QRECIP = '{
        16'h0800, 16'h0B8A, 16'h0C3E, 16'h0AD3, 16'h0800, 16'h0573, 16'h03B2, 16'h01C9,
        16'h0A6E, 16'h0F68, 16'h0E98, 16'h0B5D, 16'h07E5, 16'h03C1, 16'h02D1, 16'h0213,
        16'h0A7D, 16'h0C76, 16'h0A7D, 16'h0951, 16'h05F4, 16'h03A5, 16'h0267, 16'h01E5,
        16'h0A7D, 16'h0A2E, 16'h08C8, 16'h0716, 16'h03F4, 16'h026C, 16'h01DE, 16'h01A5,
        16'h0800, 16'h07F1, 16'h0603, 16'h03E4, 16'h02A6, 16'h01AD, 16'h015A, 16'h0144,
        16'h0573, 16'h055E, 16'h0388, 16'h027E, 16'h01DE, 16'h0161, 16'h0141, 16'h0158,
        16'h03B2, 16'h027E, 16'h01D6, 16'h0189, 16'h016A, 16'h0125, 16'h0118, 16'h0125,
        16'h01E2, 16'h0185, 16'h0176, 16'h014A, 16'h0124, 16'h0133, 16'h0128, 16'h0132
    };

endpackage

// File: rtl/dct_quant_lane.sv
// One quantizer lane: signed multiply by a Q0.RECIP_W reciprocal, round half
// away from zero, saturate to OUT_W signed.
module dct_quant_lane
    import dct_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 12,
    parameter int RECIP_W = 16
) (
    input  logic signed [IN_W-1:0]    coef_i,
    input  logic        [RECIP_W-1:0] recip_i,
    output logic signed [OUT_W-1:0]   q_o
);

    localparam int PW = IN_W + RECIP_W + 1;
    localparam int MW = IN_W + 1;
    localparam logic [MW-1:0] POS_LIM = MW'((1 << (OUT_W - 1)) - 1);
    localparam logic [MW-1:0] NEG_LIM = MW'(1 << (OUT_W - 1));
    localparam logic [OUT_W-1:0] Q_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] Q_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [PW-1:0] coef_x;
    logic signed [PW-1:0] recip_x;
    logic signed [PW-1:0] prod;
    logic        [PW-1:0] mag;
    logic        [PW-1:0] rnd;
    logic        [MW-1:0] qmag;
    logic                 neg;

    assign coef_x  = PW'(coef_i);
    assign recip_x = PW'(recip_i);
    assign prod    = coef_x * recip_x;
    assign neg     = prod[PW-1];
    // Rounding on the magnitude makes halves go away from zero for both signs.
    assign mag     = neg ? -prod : prod;
    assign rnd     = mag + (PW'(1) << (RECIP_W - 1));
    assign qmag    = MW'(rnd >> RECIP_W);

    always_comb begin
        q_o = OUT_W'(qmag);
        if (neg) begin
            if (qmag > NEG_LIM) q_o = Q_MIN;
            else                q_o = OUT_W'(-qmag);
        end else if (qmag > POS_LIM) begin
            q_o = Q_MAX;
        end
    end

endmodule

// File: rtl/dct_quant_zigzag.sv
// Row-wise quantizer into ping-pong 8x8 banks; drains each full bank one
// coefficient per cycle in zigzag order.
module dct_quant_zigzag
    import dct_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 12,
    parameter int RECIP_W = 16,
    parameter logic [0:63][RECIP_W-1:0] QTAB = QRECIP
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NLANE-1:0][IN_W-1:0]  in_vec,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_W-1:0]     out_coef,
    output logic                        out_last
);

    logic [OUT_W-1:0] bank_q [2][NCOEF];

    logic [1:0] full_q,    full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] wr_row_q,  wr_row_d;
    logic [5:0] rd_idx_q,  rd_idx_d;

    logic [NLANE-1:0][OUT_W-1:0] qrow;
    logic in_acc, out_acc;

    for (genvar j = 0; j < NLANE; j++) begin : g_lane
        localparam logic [2:0] LJ = 3'(j);
        dct_quant_lane #(
            .IN_W    (IN_W),
            .OUT_W   (OUT_W),
            .RECIP_W (RECIP_W)
        ) u_lane (
            .coef_i  (in_vec[j]),
            .recip_i (QTAB[{wr_row_q, LJ}]),
            .q_o     (qrow[j])
        );
    end

    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_last  = out_valid && (rd_idx_q == 6'd63);
    assign out_coef  = bank_q[rd_bank_q][ZIGZAG[rd_idx_q]];
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;

    // The write bank is never full, so a set and a clear on the same edge
    // always land on different banks.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_idx_d  = rd_idx_q;
        if (in_acc) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        if (out_acc) begin
            rd_idx_d = rd_idx_q + 6'd1;
            if (rd_idx_q == 6'd63) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= 3'd0;
            rd_idx_q  <= 6'd0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

    // Bank contents need no reset; the full flags gate every read.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            for (int j = 0; j < NLANE; j++) begin
                bank_q[wr_bank_q][{wr_row_q, 3'(j)}] <= qrow[j];
            end
        end
    end

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Three instances (default, flat 0x8000, flat 0xFFFF tables) driven in lockstep;
// a reference quantizer fills a scoreboard checked on every output handshake.
module tb_dct_quant_zigzag;

    typedef struct {
        int c0;
        int c1;
        int c2;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [7:0][15:0] in_vec = '0;
    logic [2:0] in_ready, out_valid, out_last;
    logic signed [11:0] out_coef [3];

    int n_assert = 0;
    int n_fail = 0;
    exp_t sb[$];
    int tabs [3][64];
    int zz [64];
    int mblk [3][64];
    int mrow = 0;
    int rdy_mode = 0;
    int run_len = 0;
    int max_run = 0;
    bit hold_chk = 1'b0;
    logic signed [11:0] held = '0;

    always #5 clk = ~clk;

    dct_quant_zigzag u_dflt (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_vec(in_vec), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_coef(out_coef[0]), .out_last(out_last[0])
    );
    dct_quant_zigzag #(.QTAB({64{16'h8000}})) u_half (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_vec(in_vec), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_coef(out_coef[1]), .out_last(out_last[1])
    );
    dct_quant_zigzag #(.QTAB({64{16'hFFFF}})) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_vec(in_vec), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_coef(out_coef[2]), .out_last(out_last[2])
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: nearest integer of x*r/2^16 with halves away from zero.
    function automatic int qmodel(input int x, input int r);
        longint p, a, q;
        p = longint'(x) * longint'(r);
        a = (p < 0) ? -p : p;
        q = (2 * a + 65536) / 131072;
        if (p < 0) q = -q;
        if (q > 2047) q = 2047;
        if (q < -2048) q = -2048;
        return int'(q);
    endfunction

    task automatic model_row(input logic [7:0][15:0] v);
        exp_t e;
        for (int d = 0; d < 3; d++)
            for (int j = 0; j < 8; j++)
                mblk[d][mrow*8+j] = qmodel(int'($signed(v[j])), tabs[d][mrow*8+j]);
        if (mrow == 7) begin
            for (int k = 0; k < 64; k++) begin
                e.c0 = mblk[0][zz[k]];
                e.c1 = mblk[1][zz[k]];
                e.c2 = mblk[2][zz[k]];
                e.last = (k == 63);
                sb.push_back(e);
            end
            mrow = 0;
        end else begin
            mrow++;
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic send_row(input logic [7:0][15:0] v, output int waited);
        int t;
        t = 0;
        in_vec = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready[0] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_timeout", t < 2000, 1);
        if (in_ready[0]) model_row(v);
        waited = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int kind, input int val, output int waited);
        logic [7:0][15:0] v;
        int w;
        waited = 0;
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 8; j++) begin
                int k;
                k = r * 8 + j;
                case (kind)
                    0: v[j] = '0;
                    1: v[j] = (k == 0) ? 16'(val) : 16'h0000;
                    2: v[j] = 16'(2 * k);
                    3: v[j] = j[0] ? 16'h8000 : 16'h7FFF;
                    default: v[j] = 16'($urandom);
                endcase
            end
            send_row(v, w);
            waited += w;
        end
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid[0]) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", t < 3000, 1);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_chk = 1'b0;
            run_len = 0;
        end else begin
            if (hold_chk) begin
                chk("stall_valid", out_valid[0], 1);
                chk("stall_coef", out_coef[0], held);
            end
            if (out_valid[0] && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("coef_dflt", out_coef[0], e.c0);
                    chk("coef_half", out_coef[1], e.c1);
                    chk("coef_sat", out_coef[2], e.c2);
                    chk("out_last", out_last[0], e.last);
                end
            end
            hold_chk = out_valid[0] && !out_ready;
            held = out_coef[0];
            run_len = out_valid[0] ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
        end
    end

    initial begin
        int w;
        int s, r0, r1, n;
        n = 0;
        for (s = 0; s < 15; s++) begin
            r0 = (s > 7) ? s - 7 : 0;
            r1 = (s < 7) ? s : 7;
            if (s[0]) for (int r = r0; r <= r1; r++) begin zz[n] = r * 8 + (s - r); n++; end
            else      for (int r = r1; r >= r0; r--) begin zz[n] = r * 8 + (s - r); n++; end
        end
        for (int k = 0; k < 64; k++) begin
            tabs[0][k] = int'(dct_pkg::QRECIP[k]);
            tabs[1][k] = 32'h8000;
            tabs[2][k] = 32'hFFFF;
        end

        rdy_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready[0], 1);
        chk("reset_out_valid", out_valid[0], 0);
        chk("reset_out_last", out_last[0], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_block(0, 0, w);
        chk("zero_block_in_ready_wait", w, 0);
        wait_empty();

        send_block(1, 1024, w);
        wait_empty();
        send_block(1, 16, w);
        wait_empty();
        send_block(1, -16, w);
        wait_empty();
        send_block(2, 0, w);
        wait_empty();
        send_block(3, 0, w);
        wait_empty();

        max_run = 0;
        send_block(4, 0, w);
        send_block(4, 0, w);
        @(negedge clk);
        chk("backpressure_in_ready", in_ready[0], 0);
        @(posedge clk);
        #1;
        send_block(4, 0, w);
        wait_empty();
        chk("no_bubble_192", max_run >= 192, 1);

        rdy_mode = 1;
        send_block(4, 0, w);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        mrow = 0;
        @(negedge clk);
        chk("midreset_out_valid", out_valid[0], 0);
        chk("midreset_in_ready", in_ready[0], 1);
        chk("midreset_out_last", out_last[0], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_block(4, 0, w);
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
